// File: rtl/buzzer_tone_decoder.sv
// -----------------------------------------------------------------------------
// buzzer_tone_decoder
//   Receive side of the buzzer interface. Measures the half-period of the
//   square wave on signal_in_i by counting clk cycles between edges (rising
//   and falling) and maps it back to a note index: 1..7 = C4..B4, 0 = silence.
//   A note is reported only after STABLE_N consecutive half-periods match the
//   same reference within +/-TOL_CYC. No edge for SILENCE_CYC cycles reports
//   silence and re-arms the measurement.
//
// Ports
//   clk            in   1      system clock
//   rst            in   1      asynchronous, active-high reset
//   enable_i       in   1      decoder active; low forces note 0 silently
//   signal_in_i    in   1      buzzer square wave, asynchronous to clk
//   note_o         out  3      decoded note (0 silence, 1..7 = C D E F G A B)
//   note_valid_o   out  1      one-cycle pulse whenever note_o changes value
//   note_active_o  out  1      high while note_o != 0
//   half_period_o  out  CNT_W  last measured half-period in clk cycles
// -----------------------------------------------------------------------------
module buzzer_tone_decoder #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TOL_CYC     = 2000,
  parameter int STABLE_N    = 4,
  parameter int SILENCE_CYC = 1_000_000,
  parameter int CNT_W       = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             signal_in_i,
  output logic [2:0]       note_o,
  output logic             note_valid_o,
  output logic             note_active_o,
  output logic [CNT_W-1:0] half_period_o
);

  localparam int STAB_W = $clog2(STABLE_N + 1);
  localparam int FREQ_HZ [7] = '{262, 294, 330, 349, 392, 440, 494};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_TRACK
  } state_t;

  // Reference half-period CLK_HZ/(2*f), rounded to nearest.
  function automatic logic [CNT_W-1:0] hp_ref(input int f);
    return CNT_W'((CLK_HZ + f) / (2 * f));
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic in_tol(input logic [CNT_W-1:0] meas,
                                  input logic [CNT_W-1:0] ref_hp);
    logic [CNT_W-1:0] diff;
    diff = (meas > ref_hp) ? (meas - ref_hp) : (ref_hp - meas);
    return (diff <= CNT_W'(TOL_CYC));
  endfunction

  logic              sync1_q, sync2_q, sync3_q;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        cand_q, cand_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [2:0]        note_q, note_d;
  logic              valid_q, valid_d;
  logic              active_q;
  logic [CNT_W-1:0]  hp_q, hp_d;

  logic              edge_w;
  logic              sil_w;
  logic [2:0]        cls_w;

  // sync3 is the one-cycle-delayed copy of the synchronized pin.
  assign edge_w = sync2_q ^ sync3_q;
  // Fires on the cycle the counter would step to SILENCE_CYC.
  assign sil_w  = (cnt_q == CNT_W'(SILENCE_CYC - 1));

  always_comb begin
    cls_w = 3'd0;
    for (int k = 0; k < 7; k++) begin
      if (in_tol(cnt_q, hp_ref(FREQ_HZ[k]))) cls_w = 3'(k + 1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    stab_d  = stab_q;
    note_d  = note_q;
    valid_d = 1'b0;
    hp_d    = hp_q;

    if (!enable_i) begin
      // Disabled: drop the note without announcing it.
      state_d = S_IDLE;
      cnt_d   = '0;
      cand_d  = 3'd0;
      stab_d  = '0;
      note_d  = 3'd0;
    end else begin
      cnt_d = edge_w ? '0 : sat_inc(cnt_q);
      case (state_q)
        S_IDLE: state_d = S_ARM;
        // First edge only opens the measurement window.
        S_ARM: if (edge_w) state_d = S_TRACK;
        S_TRACK: begin
          // Edge takes priority over the silence timeout.
          if (edge_w) begin
            hp_d = cnt_q;
            if (cls_w == 3'd0) begin
              stab_d = '0;
            end else if (cls_w == cand_q) begin
              stab_d = (stab_q >= STAB_W'(STABLE_N)) ? STAB_W'(STABLE_N)
                                                     : stab_q + STAB_W'(1);
            end else begin
              cand_d = cls_w;
              stab_d = STAB_W'(1);
            end
            if ((stab_d == STAB_W'(STABLE_N)) && (cand_d != note_q)) begin
              note_d  = cand_d;
              valid_d = 1'b1;
            end
          end else if (sil_w) begin
            if (note_q != 3'd0) begin
              note_d  = 3'd0;
              valid_d = 1'b1;
            end
            cand_d  = 3'd0;
            stab_d  = '0;
            state_d = S_ARM;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cand_q   <= 3'd0;
      stab_q   <= '0;
      note_q   <= 3'd0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      hp_q     <= '0;
    end else begin
      sync1_q  <= signal_in_i;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      stab_q   <= stab_d;
      note_q   <= note_d;
      valid_q  <= valid_d;
      active_q <= (note_d != 3'd0);
      hp_q     <= hp_d;
    end
  end

  assign note_o        = note_q;
  assign note_valid_o  = valid_q;
  assign note_active_o = active_q;
  assign half_period_o = hp_q;

endmodule

// File: tb/tb_buzzer_tone_decoder.sv
// -----------------------------------------------------------------------------
// tb_buzzer_tone_decoder
//   Directed + randomized bench for buzzer_tone_decoder at a scaled-down clock
//   (250 kHz) so a full tone lock takes a few thousand cycles. A note-level
//   reference model tracks arm/candidate/stability from the half-periods the
//   bench drives and predicts note, note_valid and the pulse count.
// -----------------------------------------------------------------------------
module tb_buzzer_tone_decoder;

  localparam int CLK_HZ      = 250_000;
  localparam int TOL_CYC     = 5;
  localparam int STABLE_N    = 4;
  localparam int SILENCE_CYC = 1000;
  localparam int CNT_W       = 11;
  localparam int FREQ [7]    = '{262, 294, 330, 349, 392, 440, 494};

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             sig;
  logic [2:0]       note_o;
  logic             note_valid_o;
  logic             note_active_o;
  logic [CNT_W-1:0] half_period_o;

  buzzer_tone_decoder #(
    .CLK_HZ     (CLK_HZ),
    .TOL_CYC    (TOL_CYC),
    .STABLE_N   (STABLE_N),
    .SILENCE_CYC(SILENCE_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable),
    .signal_in_i  (sig),
    .note_o       (note_o),
    .note_valid_o (note_valid_o),
    .note_active_o(note_active_o),
    .half_period_o(half_period_o)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;
  bit prev_vld    = 1'b0;

  // Reference model state
  int hp_tab [7];
  bit m_armed;
  int m_cand, m_stab, m_note, m_prev, m_pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse monitor: counts note_valid pulses, never two in a row.
  always @(negedge clk) begin
    if (note_valid_o === 1'b1) begin
      pulses++;
      vectors++;
      assert (!prev_vld) else begin
        miscompares++;
        $error("FAIL vld_back_to_back observed=1 expected=0");
      end
    end
    prev_vld = (note_valid_o === 1'b1);
  end

  function automatic int classify(input int gap);
    int c = 0;
    for (int k = 0; k < 7; k++) begin
      int d = gap - hp_tab[k];
      if (d < 0) d = -d;
      if (d <= TOL_CYC) c = k + 1;
    end
    return c;
  endfunction

  task automatic model_clear();
    m_armed = 1'b0;
    m_cand  = 0;
    m_stab  = 0;
    m_note  = 0;
  endtask

  task automatic model_edge(output bit pulse);
    int c;
    pulse = 1'b0;
    if (!m_armed) begin
      m_armed = 1'b1;
    end else begin
      c = classify(m_prev);
      if (c == 0) m_stab = 0;
      else if (c == m_cand) m_stab = (m_stab < STABLE_N) ? m_stab + 1 : STABLE_N;
      else begin
        m_cand = c;
        m_stab = 1;
      end
      if (m_stab == STABLE_N && m_cand != m_note) begin
        m_note = m_cand;
        pulse  = 1'b1;
        m_pulses++;
      end
    end
  endtask

  // Toggle the pin, then hold it for n cycles. Called at posedge+1; the
  // decoder's answer to this edge lands 3 clocks after the toggle.
  task automatic edge_hold(input int n, input string tag);
    int old_note;
    bit pulse;
    old_note = m_note;
    sig = ~sig;
    model_edge(pulse);
    m_prev = n;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_pre"}, 32'(note_o), 32'(old_note));
    @(posedge clk);
    #1;
    check({tag, "_note"}, 32'(note_o), 32'(m_note));
    check({tag, "_vld"}, 32'(note_valid_o), 32'(pulse));
    check({tag, "_act"}, 32'(note_active_o), 32'(m_note != 0));
    repeat (n - 3) @(posedge clk);
    #1;
  endtask

  task automatic tone(input int k, input int edges, input int jit, input string tag);
    for (int i = 0; i < edges; i++) begin
      int j = 0;
      if (jit > 0) j = int'($urandom_range(0, 2 * jit)) - jit;
      edge_hold(hp_tab[k] + j, tag);
    end
  endtask

  task automatic go_idle(input string tag);
    enable = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    check({tag, "_idle_note"}, 32'(note_o), 32'd0);
    check({tag, "_idle_vld"}, 32'(note_valid_o), 32'd0);
    check({tag, "_idle_act"}, 32'(note_active_o), 32'd0);
    check({tag, "_idle_pulses"}, 32'(pulses), 32'(m_pulses));
    enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int p0, d;
    for (int k = 0; k < 7; k++)
      hp_tab[k] = int'($floor(real'(CLK_HZ) / (2.0 * real'(FREQ[k])) + 0.5));
    model_clear();
    m_prev = 0;
    m_pulses = 0;
    rst = 1'b1;
    enable = 1'b0;
    sig = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_note", 32'(note_o), 32'd0);
    check("rst_vld", 32'(note_valid_o), 32'd0);
    check("rst_act", 32'(note_active_o), 32'd0);
    check("rst_hp", 32'(half_period_o), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: 440 Hz exact half-periods -> A (6) after arm + 4 edges
    enable = 1'b1;
    @(posedge clk);
    #1;
    tone(5, 6, 0, "t1");
    check("t1_note", 32'(note_o), 32'd6);
    check("t1_act", 32'(note_active_o), 32'd1);
    d = int'(half_period_o) - hp_tab[5];
    check("t1_hp_within1", 32'((d <= 1) && (d >= -1)), 32'd1);
    check("t1_pulses", 32'(pulses), 32'd1);

    // 2: 262 Hz then 494 Hz -> two pulses
    go_idle("t2");
    p0 = pulses;
    tone(0, 6, 2, "t2c");
    check("t2_note_c", 32'(note_o), 32'd1);
    tone(6, 6, 2, "t2b");
    check("t2_note_b", 32'(note_o), 32'd7);
    check("t2_two_pulses", 32'(pulses - p0), 32'd2);

    // 3: out-of-tolerance half-period while E (3) is held
    go_idle("t3");
    p0 = pulses;
    tone(2, 5, 2, "t3e");
    edge_hold(400, "t3_bad");
    tone(2, 6, 2, "t3r");
    check("t3_note", 32'(note_o), 32'd3);
    check("t3_one_pulse", 32'(pulses - p0), 32'd1);

    // 4: stop toggling while G (5) -> silence after SILENCE_CYC
    go_idle("t4");
    tone(4, 5, 2, "t4g");
    edge_hold(SILENCE_CYC + 2, "t4_last");
    check("t4_before_sil", 32'(note_o), 32'd5);
    @(posedge clk);
    #1;
    check("t4_sil_note", 32'(note_o), 32'd0);
    check("t4_sil_vld", 32'(note_valid_o), 32'd1);
    check("t4_sil_act", 32'(note_active_o), 32'd0);
    model_clear();
    m_pulses++;
    @(posedge clk);
    #1;
    check("t4_sil_vld_end", 32'(note_valid_o), 32'd0);
    tone(4, 5, 2, "t4re");
    check("t4_relock", 32'(note_o), 32'd5);

    // 5: reset mid-tone, re-lock, then enable drop mid-tone
    tone(1, 5, 2, "t5d");
    check("t5_note_d", 32'(note_o), 32'd2);
    rst = 1'b1;
    #1;
    check("t5_rst_note", 32'(note_o), 32'd0);
    check("t5_rst_vld", 32'(note_valid_o), 32'd0);
    check("t5_rst_act", 32'(note_active_o), 32'd0);
    check("t5_rst_hp", 32'(half_period_o), 32'd0);
    sig = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tone(3, 5, 2, "t5f");
    check("t5_relock_f", 32'(note_o), 32'd4);
    go_idle("t5");

    // 6: short glitch inside a stable G tone
    p0 = pulses;
    tone(4, 6, 2, "t6g");
    edge_hold(150, "t6_a");
    edge_hold(4, "t6_glitch");
    edge_hold(165, "t6_b");
    tone(4, 6, 2, "t6r");
    check("t6_note", 32'(note_o), 32'd5);
    check("t6_one_pulse", 32'(pulses - p0), 32'd1);

    // Random tone sequence, switching without idling
    for (int r = 0; r < 4; r++) begin
      tone(int'($urandom_range(0, 6)), int'($urandom_range(5, 7)), 2, "rnd");
    end
    check("rnd_pulses", 32'(pulses), 32'(m_pulses));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
